// File: rtl/ahb_bus_arbiter_if.sv
// AHB arbitration signal bundle shared between the request side and the arbiter.
// The request side drives requests and bus status; the arbiter answers with grant and owner.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [1:0]             HMASTER;
  logic                   HMASTLOCK;

  modport master (
    output HBUSREQ,
    output HLOCK,
    output HTRANS,
    output HBURST,
    output HREADY,
    input  HGRANT,
    input  HMASTER,
    input  HMASTLOCK
  );

  modport slave (
    input  HBUSREQ,
    input  HLOCK,
    input  HTRANS,
    input  HBURST,
    input  HREADY,
    output HGRANT,
    output HMASTER,
    output HMASTLOCK
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter for up to four masters.
// Holds the grant across fixed bursts, bounded INCR bursts and locked sequences.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16
) (
  input logic               HCLK,
  input logic               HRESET,
  ahb_bus_arbiter_if.slave  bus
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BR_SINGLE = 3'b000;
  localparam logic [2:0] BR_INCR   = 3'b001;
  localparam logic [1:0] DEF_IDX   = 2'(DEFAULT_MASTER);

  typedef enum logic [1:0] {
    ARB,
    BURST,
    INCR,
    LOCKED
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] master_q, master_d;
  logic       mlock_q, mlock_d;
  logic [4:0] cnt_q, cnt_d;

  logic [3:0] req4;
  logic [3:0] lock4;
  logic       own_req;
  logic       own_lock;
  logic       others;
  logic       is_idle;
  logic       is_nonseq;
  logic       is_seq;
  logic [1:0] rr_idx;

  assign req4      = 4'(bus.HBUSREQ);
  assign lock4     = 4'(bus.HLOCK);
  assign own_req   = req4[gnt_q];
  // A lock request only counts while the same master is requesting.
  assign own_lock  = own_req & lock4[gnt_q];
  assign others    = |(req4 & ~(4'b0001 << gnt_q));
  assign is_idle   = (bus.HTRANS == TR_IDLE);
  assign is_nonseq = (bus.HTRANS == TR_NONSEQ);
  assign is_seq    = (bus.HTRANS == TR_SEQ);

  function automatic logic [4:0] burst_beats(
    input logic [2:0] b
  );
    logic [4:0] n;
    unique case (1'b1)
      b == BR_SINGLE:   n = 5'd0;
      b == BR_INCR:     n = 5'(MAX_HOLD - 1);
      b[2:1] == 2'b01:  n = 5'd3;
      b[2:1] == 2'b10:  n = 5'd7;
      default:          n = 5'd15;
    endcase
    return n;
  endfunction

  // Search begins just after the current grantee and ends on it.
  always_comb begin
    logic [2:0] c;
    logic       found;
    rr_idx = DEF_IDX;
    found  = 1'b0;
    c      = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      c = 3'(gnt_q) + 3'(k);
      if (c >= 3'(NUM_MASTERS)) begin
        c = c - 3'(NUM_MASTERS);
      end
      if (!found && req4[c[1:0]]) begin
        rr_idx = c[1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    master_d = master_q;
    mlock_d  = mlock_q;
    cnt_d    = cnt_q;
    if (bus.HREADY) begin
      master_d = gnt_q;
      mlock_d  = own_lock;
      if (is_nonseq) begin
        cnt_d = burst_beats(bus.HBURST);
      end else if (is_seq && cnt_q != 5'd0) begin
        cnt_d = cnt_q - 5'd1;
      end
      unique case (state_q)
        ARB: begin
          if (own_lock) begin
            state_d = LOCKED;
          end else if (is_nonseq &&
                       bus.HBURST == BR_INCR) begin
            state_d = INCR;
          end else if (is_nonseq &&
                       bus.HBURST != BR_SINGLE) begin
            state_d = BURST;
          end else begin
            gnt_d = rr_idx;
          end
        end
        BURST: begin
          // Last beat re-arbitrates so the next owner follows directly.
          if (is_idle || is_nonseq ||
              cnt_q == 5'd0 ||
              (is_seq && cnt_q == 5'd1)) begin
            gnt_d   = rr_idx;
            state_d = ARB;
          end
        end
        INCR: begin
          if (!own_req ||
              (cnt_d == 5'd0 && others)) begin
            gnt_d   = rr_idx;
            state_d = ARB;
          end
        end
        LOCKED: begin
          if (!own_lock) begin
            gnt_d   = rr_idx;
            state_d = ARB;
          end
        end
        default: begin
          state_d = ARB;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ARB;
      gnt_q    <= DEF_IDX;
      master_q <= DEF_IDX;
      mlock_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      master_q <= master_d;
      mlock_q  <= mlock_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    bus.HGRANT = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      bus.HGRANT[i] = (gnt_q == 2'(i));
    end
  end

  assign bus.HMASTER   = master_q;
  assign bus.HMASTLOCK = mlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: a burst-level model checked every cycle,
// plus literal expectations at the interesting edges.
module tb_ahb_bus_arbiter;

  localparam int NM   = 2;
  localparam int DEFM = 0;
  localparam int MAXH = 4;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;

  logic HCLK = 1'b0;
  logic HRESET;
  int   errs   = 0;
  int   checks = 0;

  ahb_bus_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  ahb_bus_arbiter #(
    .NUM_MASTERS   (NM),
    .DEFAULT_MASTER(DEFM),
    .MAX_HOLD      (MAXH)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  // ---------------- model ----------------
  // mode: 0 free, 1 fixed burst, 2 undefined INCR, 3 locked
  int m_gnt, m_own, m_lk, mode, left, taken;

  function automatic int rr_pick(input int from, input logic [NM-1:0] req);
    int c;
    for (int k = 1; k <= NM; k++) begin
      c = (from + k) % NM;
      if (req[c]) return c;
    end
    return DEFM;
  endfunction

  function automatic int burst_len(input logic [2:0] b);
    case (b)
      3'b010, 3'b011: return 4;
      3'b100, 3'b101: return 8;
      default:        return 16;
    endcase
  endfunction

  always @(posedge HCLK or posedge HRESET) begin : model
    int  g;
    bit  lk, free, oth;
    if (HRESET) begin
      m_gnt = DEFM; m_own = DEFM; m_lk = 0;
      mode = 0; left = 0; taken = 0;
    end else if (bus.HREADY) begin
      g    = m_gnt;
      lk   = bus.HBUSREQ[g] && bus.HLOCK[g];
      oth  = 0;
      for (int i = 0; i < NM; i++) if (i != g && bus.HBUSREQ[i]) oth = 1;
      free = 0;
      case (mode)
        0: begin
          if (lk) mode = 3;
          else if (bus.HTRANS == NONSEQ && bus.HBURST == INCR) begin
            mode = 2; taken = 1;
          end else if (bus.HTRANS == NONSEQ && bus.HBURST != SINGLE) begin
            mode = 1; left = burst_len(bus.HBURST) - 1;
          end else free = 1;
        end
        1: begin
          if (bus.HTRANS == IDLE || bus.HTRANS == NONSEQ) free = 1;
          else if (bus.HTRANS == SEQ) begin
            left--;
            if (left == 0) free = 1;
          end
        end
        2: begin
          if (bus.HTRANS == NONSEQ) taken = 1;
          else if (bus.HTRANS == SEQ) taken++;
          if (!bus.HBUSREQ[g]) free = 1;
          else if (taken >= MAXH && oth) free = 1;
        end
        default: if (!lk) free = 1;
      endcase
      if (free) begin
        m_gnt = rr_pick(g, bus.HBUSREQ);
        mode  = 0;
      end
      m_own = g;
      m_lk  = lk ? 1 : 0;
    end
  end

  always @(negedge HCLK) begin
    checks++;
    if (bus.HGRANT !== NM'(1 << m_gnt)) begin
      errs++;
      $display("FAIL model grant t=%0t got=%b exp=%b", $time, bus.HGRANT, NM'(1 << m_gnt));
    end
    checks++;
    if (bus.HMASTER !== 2'(m_own)) begin
      errs++;
      $display("FAIL model master t=%0t got=%0d exp=%0d", $time, bus.HMASTER, m_own);
    end
    checks++;
    if (bus.HMASTLOCK !== (m_lk != 0)) begin
      errs++;
      $display("FAIL model mastlock t=%0t got=%b exp=%0d", $time, bus.HMASTLOCK, m_lk);
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] rq, input logic [1:0] lk,
                     input logic [1:0] tr, input logic [2:0] bu,
                     input logic rdy);
    bus.HBUSREQ = rq;
    bus.HLOCK   = lk;
    bus.HTRANS  = tr;
    bus.HBURST  = bu;
    bus.HREADY  = rdy;
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    bus.HBUSREQ = '0;
    bus.HLOCK   = '0;
    bus.HTRANS  = IDLE;
    bus.HBURST  = SINGLE;
    bus.HREADY  = 1'b1;
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
  endtask

  initial begin
    HRESET = 1'b1;
    bus.HBUSREQ = '0;
    bus.HLOCK   = '0;
    bus.HTRANS  = IDLE;
    bus.HBURST  = SINGLE;
    bus.HREADY  = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_grant", 32'(bus.HGRANT), 32'h1);
    chk("rst_master", 32'(bus.HMASTER), 32'h0);
    chk("rst_mlock", 32'(bus.HMASTLOCK), 32'h0);
    HRESET = 1'b0;

    // idle bus stays with the default master
    repeat (5) cyc(2'b00, 2'b00, IDLE, SINGLE, 1'b1);
    chk("idle_grant", 32'(bus.HGRANT), 32'h1);
    chk("idle_master", 32'(bus.HMASTER), 32'h0);

    // both requesting singles: grant alternates, owner trails by one
    for (int i = 0; i < 6; i++) begin
      cyc(2'b11, 2'b00, NONSEQ, SINGLE, 1'b1);
      chk("rr_grant", 32'(bus.HGRANT), (i % 2 == 0) ? 32'h2 : 32'h1);
      chk("rr_master", 32'(bus.HMASTER), (i % 2 == 0) ? 32'h0 : 32'h1);
    end
    cyc(2'b00, 2'b00, IDLE, SINGLE, 1'b1);
    chk("noreq_default", 32'(bus.HGRANT), 32'h1);

    // INCR4 from M0 with two wait states while M1 requests
    do_reset();
    cyc(2'b11, 2'b00, NONSEQ, INCR4, 1'b1);
    chk("b4_beat1", 32'(bus.HGRANT), 32'h1);
    cyc(2'b11, 2'b00, SEQ, INCR4, 1'b1);
    chk("b4_beat2", 32'(bus.HGRANT), 32'h1);
    cyc(2'b11, 2'b00, SEQ, INCR4, 1'b0);
    cyc(2'b11, 2'b00, SEQ, INCR4, 1'b0);
    chk("b4_wait", 32'(bus.HGRANT), 32'h1);
    cyc(2'b11, 2'b00, SEQ, INCR4, 1'b1);
    chk("b4_beat3", 32'(bus.HGRANT), 32'h1);
    cyc(2'b11, 2'b00, SEQ, INCR4, 1'b1);
    chk("b4_beat4", 32'(bus.HGRANT), 32'h2);
    chk("b4_master", 32'(bus.HMASTER), 32'h0);
    cyc(2'b11, 2'b00, IDLE, SINGLE, 1'b1);
    cyc(2'b00, 2'b00, IDLE, SINGLE, 1'b1);

    // M1 locked sequence while M0 requests
    do_reset();
    cyc(2'b11, 2'b10, NONSEQ, SINGLE, 1'b1);
    chk("lk_grant0", 32'(bus.HGRANT), 32'h2);
    for (int i = 0; i < 6; i++) begin
      cyc(2'b11, 2'b10, NONSEQ, SINGLE, 1'b1);
      chk("lk_grant", 32'(bus.HGRANT), 32'h2);
      chk("lk_mlock", 32'(bus.HMASTLOCK), 32'h1);
    end
    cyc(2'b11, 2'b00, NONSEQ, SINGLE, 1'b1);
    chk("lk_release", 32'(bus.HGRANT), 32'h1);
    chk("lk_mlock_off", 32'(bus.HMASTLOCK), 32'h0);
    cyc(2'b00, 2'b00, IDLE, SINGLE, 1'b1);

    // INCR with contention: released after MAX_HOLD beats
    do_reset();
    cyc(2'b11, 2'b00, NONSEQ, INCR, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc(2'b11, 2'b00, SEQ, INCR, 1'b1);
      chk("incr_hold", 32'(bus.HGRANT), 32'h1);
    end
    cyc(2'b11, 2'b00, SEQ, INCR, 1'b1);
    chk("incr_release", 32'(bus.HGRANT), 32'h2);
    cyc(2'b00, 2'b00, IDLE, SINGLE, 1'b1);

    // INCR without contention: counter saturates, bus kept
    do_reset();
    cyc(2'b01, 2'b00, NONSEQ, INCR, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc(2'b01, 2'b00, (i == 3) ? BUSY : SEQ, INCR, 1'b1);
      chk("incr_solo", 32'(bus.HGRANT), 32'h1);
    end
    cyc(2'b11, 2'b00, SEQ, INCR, 1'b1);
    chk("incr_late_req", 32'(bus.HGRANT), 32'h2);
    cyc(2'b00, 2'b00, IDLE, SINGLE, 1'b1);

    // async reset in the middle of an M1 INCR8
    do_reset();
    cyc(2'b10, 2'b00, IDLE, SINGLE, 1'b1);
    cyc(2'b10, 2'b00, IDLE, SINGLE, 1'b1);
    cyc(2'b10, 2'b00, NONSEQ, INCR8, 1'b1);
    cyc(2'b10, 2'b00, SEQ, INCR8, 1'b1);
    cyc(2'b10, 2'b00, SEQ, INCR8, 1'b1);
    chk("i8_grant", 32'(bus.HGRANT), 32'h2);
    chk("i8_master", 32'(bus.HMASTER), 32'h1);
    #2;
    HRESET = 1'b1;
    #1;
    chk("arst_grant", 32'(bus.HGRANT), 32'h1);
    chk("arst_master", 32'(bus.HMASTER), 32'h0);
    chk("arst_mlock", 32'(bus.HMASTLOCK), 32'h0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    cyc(2'b00, 2'b00, IDLE, SINGLE, 1'b1);
    chk("post_rst", 32'(bus.HGRANT), 32'h1);

    @(negedge HCLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
